// File: rtl/decode_stage_hzd.sv
// -----------------------------------------------------------------------------
// decode_stage_hzd
//   Instruction-decode stage with its ID/EX pipeline register for the 20-bit
//   ISA core. It holds the architectural register file (with write-through
//   bypass from writeback), detects load-use hazards against the instruction
//   sitting in EX, and steers the ID/EX register through flush, hold, bubble
//   or normal advance. Two saturating counters record bubbles and flushes.
//   Control decode and immediate extension live upstream and arrive on
//   ctrl_d / imm_d.
// -----------------------------------------------------------------------------
module decode_stage_hzd #(
  parameter int DATA_W  = 22,
  parameter int INSTR_W = 20,
  parameter int REG_AW  = 3,
  parameter int RD_W    = 5,
  parameter int RS1_LSB = 11,
  parameter int RS2_LSB = 8,
  parameter int RD_LSB  = 0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  // decode-side instruction
  input  logic [INSTR_W-1:0] instr_d,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] pc_d,
  input  logic [DATA_W-1:0] pcplus_d,
  input  logic [7:0]        ctrl_d,
  input  logic [DATA_W-1:0] imm_d,
  // writeback port
  input  logic              we_w,
  input  logic [RD_W-1:0]   rd_w,
  input  logic [DATA_W-1:0] wd_w,
  // pipeline control
  input  logic              flush_e,
  input  logic              stall_ext,
  output logic              stall_d,
  // ID/EX register
  output logic              valid_e,
  output logic [7:0]        ctrl_e,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [DATA_W-1:0] imm_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [RD_W-1:0]   rd_e,
  output logic [DATA_W-1:0] pc_e,
  output logic [DATA_W-1:0] pcplus_e,
  // performance counters
  output logic [CNT_W-1:0]  hazard_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int NUM_REGS      = 2 ** REG_AW;
  // Bit positions inside the control byte
  // {ALUCtl[2:0], Branch, ResultSrc(load), MemWrite, ALUSrc, RegWrite}
  localparam int CTRL_LOAD     = 3;
  localparam int CTRL_REGWRITE = 0;

  // Everything the ID/EX register carries, kept together so hold/load/clear
  // can be expressed as one assignment.
  typedef struct packed {
    logic              valid;
    logic [7:0]        ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pcplus;
  } id_ex_t;

  // ---------------------------------------------------------------------------
  // Instruction field extraction
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [RD_W-1:0]   rd_d;
  logic              unused_instr;

  assign rs1_d = instr_d[RS1_LSB +: REG_AW];
  assign rs2_d = instr_d[RS2_LSB +: REG_AW];
  assign rd_d  = instr_d[RD_LSB  +: RD_W];
  // Opcode/funct bits are decoded upstream; only the register fields matter here.
  assign unused_instr = ^instr_d;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [REG_AW-1:0] wb_idx;
  logic              wb_en;
  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] rd2_d;

  // A destination whose upper bits are set names a register outside this file
  // and is ignored, as is register 0.
  assign wb_idx = rd_w[REG_AW-1:0];
  assign wb_en  = we_w && (rd_w != '0) && ((rd_w >> REG_AW) == '0);

  // Register file storage: writeback commit on the rising edge.
  // NOTE: the array is cleared by reset on purpose -- software may read any
  // register before writing it and must see zero; a RAM macro could not do this.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values;
      // a blocking = here would make ordering between blocks matter.
      rf_q[wb_idx] <= wd_w;
    end
  end

  // Combinational read ports with write-through bypass from writeback.
  always_comb begin
    // NOTE: every output of this block gets a value before any condition is
    // tested, so no path can leave it unassigned and infer a latch.
    rd1_d = rf_q[rs1_d];
    rd2_d = rf_q[rs2_d];
    if (rs1_d == '0) begin
      rd1_d = '0;
    end else if (wb_en && (wb_idx == rs1_d)) begin
      rd1_d = wd_w;
    end
    if (rs2_d == '0) begin
      rd2_d = '0;
    end else if (wb_en && (wb_idx == rs2_d)) begin
      rd2_d = wd_w;
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard detection
  // ---------------------------------------------------------------------------
  id_ex_t ex_q;
  id_ex_t ex_d;
  logic   ex_is_load;
  logic   rs1_hit;
  logic   rs2_hit;
  logic   haz;

  // A load that writes a register is the only EX producer that cannot forward
  // in time; the source indices are widened to the destination field width so
  // an out-of-file destination never aliases a real register.
  assign ex_is_load = ex_q.valid && ex_q.ctrl[CTRL_LOAD] && ex_q.ctrl[CTRL_REGWRITE];
  assign rs1_hit    = (ex_q.rd == RD_W'(rs1_d));
  assign rs2_hit    = (ex_q.rd == RD_W'(rs2_d));
  assign haz        = valid_d && ex_is_load && (ex_q.rd != '0) && (rs1_hit || rs2_hit);

  // A flush discards the decode instruction anyway, so it never holds fetch.
  assign stall_d = !flush_e && (haz || stall_ext);

  // ---------------------------------------------------------------------------
  // ID/EX next-state selection
  // ---------------------------------------------------------------------------
  logic flush_evt;
  logic bubble_evt;

  // Priority: flush, external hold, load-use bubble, normal advance.
  always_comb begin
    ex_d       = ex_q;
    flush_evt  = 1'b0;
    bubble_evt = 1'b0;
    if (flush_e) begin
      ex_d      = '0;
      flush_evt = 1'b1;
    end else if (stall_ext) begin
      ex_d = ex_q;
    end else if (haz) begin
      // Data fields hold; only the validity/control are killed.
      ex_d.valid = 1'b0;
      ex_d.ctrl  = '0;
      bubble_evt = 1'b1;
    end else begin
      ex_d.valid  = valid_d;
      ex_d.ctrl   = valid_d ? ctrl_d : 8'h00;
      ex_d.rd1    = rd1_d;
      ex_d.rd2    = rd2_d;
      ex_d.imm    = imm_d;
      ex_d.rs1    = rs1_d;
      ex_d.rs2    = rs2_d;
      ex_d.rd     = rd_d;
      ex_d.pc     = pc_d;
      ex_d.pcplus = pcplus_d;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hazard_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Count bubbles and flushes, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hazard_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (bubble_evt && (hazard_cnt_q != '1)) begin
        hazard_cnt_q <= hazard_cnt_q + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign valid_e    = ex_q.valid;
  assign ctrl_e     = ex_q.ctrl;
  assign rd1_e      = ex_q.rd1;
  assign rd2_e      = ex_q.rd2;
  assign imm_e      = ex_q.imm;
  assign rs1_e      = ex_q.rs1;
  assign rs2_e      = ex_q.rs2;
  assign rd_e       = ex_q.rd;
  assign pc_e       = ex_q.pc;
  assign pcplus_e   = ex_q.pcplus;
  assign hazard_cnt = hazard_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_decode_stage_hzd.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_hzd
//   Bench for decode_stage_hzd. Two instances share all inputs: the default
//   one, and one with 2-bit counters to observe saturation. Instructions that
//   are expected to reach EX are pushed to a scoreboard when driven and popped
//   after the edge that should have registered them.
// -----------------------------------------------------------------------------
module tb_decode_stage_hzd;

  localparam int DATA_W  = 22;
  localparam int INSTR_W = 20;
  localparam int REG_AW  = 3;
  localparam int RD_W    = 5;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [INSTR_W-1:0] instr_d;
  logic               valid_d;
  logic [DATA_W-1:0]  pc_d, pcplus_d, imm_d, wd_w;
  logic [7:0]         ctrl_d;
  logic               we_w, flush_e, stall_ext;
  logic [RD_W-1:0]    rd_w;

  logic               stall_d, valid_e;
  logic [7:0]         ctrl_e;
  logic [DATA_W-1:0]  rd1_e, rd2_e, imm_e, pc_e, pcplus_e;
  logic [REG_AW-1:0]  rs1_e, rs2_e;
  logic [RD_W-1:0]    rd_e;
  logic [CNT_W-1:0]   hazard_cnt, flush_cnt;

  logic               s_stall_d, s_valid_e;
  logic [7:0]         s_ctrl_e;
  logic [DATA_W-1:0]  s_rd1_e, s_rd2_e, s_imm_e, s_pc_e, s_pcplus_e;
  logic [REG_AW-1:0]  s_rs1_e, s_rs2_e;
  logic [RD_W-1:0]    s_rd_e;
  logic [SAT_W-1:0]   s_hazard_cnt, s_flush_cnt;

  decode_stage_hzd dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
    .pcplus_d(pcplus_d), .ctrl_d(ctrl_d), .imm_d(imm_d), .we_w(we_w), .rd_w(rd_w),
    .wd_w(wd_w), .flush_e(flush_e), .stall_ext(stall_ext), .stall_d(stall_d),
    .valid_e(valid_e), .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e), .pcplus_e(pcplus_e),
    .hazard_cnt(hazard_cnt), .flush_cnt(flush_cnt)
  );

  decode_stage_hzd #(.CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
    .pcplus_d(pcplus_d), .ctrl_d(ctrl_d), .imm_d(imm_d), .we_w(we_w), .rd_w(rd_w),
    .wd_w(wd_w), .flush_e(flush_e), .stall_ext(stall_ext), .stall_d(s_stall_d),
    .valid_e(s_valid_e), .ctrl_e(s_ctrl_e), .rd1_e(s_rd1_e), .rd2_e(s_rd2_e),
    .imm_e(s_imm_e), .rs1_e(s_rs1_e), .rs2_e(s_rs2_e), .rd_e(s_rd_e), .pc_e(s_pc_e),
    .pcplus_e(s_pcplus_e), .hazard_cnt(s_hazard_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct packed {
    logic              valid;
    logic [7:0]        ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pcplus;
  } e_t;

  e_t                sb[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] exp_rf [8];
  int                exp_haz   = 0;
  int                exp_flush = 0;

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [2:0] rs1,
                                                  input logic [2:0] rs2,
                                                  input logic [4:0] rd);
    logic [INSTR_W-1:0] v;
    v        = '0;
    v[13:11] = rs1;
    v[10:8]  = rs2;
    v[4:0]   = rd;
    return v;
  endfunction

  function automatic logic wb_ok();
    return we_w && (rd_w != 5'd0) && (rd_w[4:3] == 2'b00);
  endfunction

  function automatic logic [DATA_W-1:0] exp_read(input logic [2:0] idx);
    if (idx == 3'd0) return '0;
    if (wb_ok() && (rd_w[2:0] == idx)) return wd_w;
    return exp_rf[idx];
  endfunction

  // Expected EX contents if the currently driven decode inputs advance.
  function automatic e_t exp_load();
    e_t e;
    e.valid  = valid_d;
    e.ctrl   = valid_d ? ctrl_d : 8'h00;
    e.rd1    = exp_read(instr_d[13:11]);
    e.rd2    = exp_read(instr_d[10:8]);
    e.imm    = imm_d;
    e.rs1    = instr_d[13:11];
    e.rs2    = instr_d[10:8];
    e.rd     = instr_d[4:0];
    e.pc     = pc_d;
    e.pcplus = pcplus_d;
    return e;
  endfunction

  function automatic e_t obs_e();
    e_t o;
    o.valid  = valid_e;
    o.ctrl   = ctrl_e;
    o.rd1    = rd1_e;
    o.rd2    = rd2_e;
    o.imm    = imm_e;
    o.rs1    = rs1_e;
    o.rs2    = rs2_e;
    o.rd     = rd_e;
    o.pc     = pc_e;
    o.pcplus = pcplus_e;
    return o;
  endfunction

  // Advance one clock; commit the writeback to the reference register file.
  task automatic tick();
    @(posedge clk);
    if (rst && wb_ok()) exp_rf[rd_w[2:0]] = wd_w;
    #1;
  endtask

  task automatic idle();
    instr_d = '0; valid_d = 1'b0; pc_d = '0; pcplus_d = '0; ctrl_d = '0;
    imm_d = '0; we_w = 1'b0; rd_w = '0; wd_w = '0; flush_e = 1'b0; stall_ext = 1'b0;
  endtask

  task automatic issue(input logic [INSTR_W-1:0] instr, input logic [7:0] ctrl,
                       input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc);
    instr_d = instr; valid_d = 1'b1; ctrl_d = ctrl; imm_d = imm;
    pc_d = pc; pcplus_d = pc + 22'd4;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    exp_haz = 0; exp_flush = 0; sb.delete();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    e_t e, o;
    idle();
    for (int i = 1; i < 8; i++) begin
      we_w = 1'b1; rd_w = RD_W'(i); wd_w = DATA_W'(22'h1000 + i * 22'h111);
      tick();
    end
    idle();
    issue(mk_instr(3'd1, 3'd2, 5'd5), 8'h01, 22'h55, 22'h100);
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL pre_reset_load: got %h want %h", o, e); end
    // Asynchronous reset mid-cycle, no clock edge in between.
    rst = 1'b0;
    clear_model();
    #1;
    o = obs_e(); n_checks++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_e_regs: got %h want 0", o); end
    n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL reset_stall_d: got %b want 0", stall_d); end
    n_checks++;
    if (hazard_cnt !== '0 || flush_cnt !== '0 || s_hazard_cnt !== '0 || s_flush_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d/%0d/%0d want 0", hazard_cnt, flush_cnt,
               s_hazard_cnt, s_flush_cnt);
    end
    #1 rst = 1'b1;
    idle();
    // Every register must read back zero.
    for (int i = 1; i < 8; i++) begin
      issue(mk_instr(3'(i), 3'(i), 5'd1), 8'h01, '0, DATA_W'(i * 4));
      sb.push_back(exp_load());
      tick();
      e = sb.pop_front(); o = obs_e(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rf_cleared_r%0d: got %h want %h", i, o, e); end
    end
    idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_bypass();
    e_t e, o;
    idle();
    we_w = 1'b1; rd_w = 5'd5; wd_w = 22'h15555;
    tick();
    issue(mk_instr(3'd3, 3'd5, 5'd7), 8'h01, 22'h1, 22'h200);
    we_w = 1'b1; rd_w = 5'd3; wd_w = 22'h2AAAA;
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL bypass_same_cycle: got %h want %h", o, e); end
    n_checks++;
    if (rd1_e !== 22'h2AAAA) begin n_fail++; $display("FAIL bypass_rd1: got %h want 2aaaa", rd1_e); end
    // Writes to register 0 are dropped and never bypassed.
    issue(mk_instr(3'd0, 3'd3, 5'd1), 8'h01, 22'h2, 22'h204);
    rd_w = 5'd0; wd_w = 22'h3FFFFF;
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL write_r0_ignored: got %h want %h", o, e); end
    // Destination with upper bits set aliases nothing.
    issue(mk_instr(3'd3, 3'd0, 5'd1), 8'h01, 22'h3, 22'h208);
    rd_w = 5'b01011; wd_w = 22'h12345;
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL write_out_of_range_same: got %h want %h", o, e); end
    we_w = 1'b0;
    issue(mk_instr(3'd3, 3'd5, 5'd1), 8'h01, 22'h4, 22'h20C);
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL write_out_of_range_after: got %h want %h", o, e); end
    idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_use();
    e_t e, o;
    idle();
    // rs2 dependency on a load.
    issue(mk_instr(3'd0, 3'd0, 5'd2), 8'h09, 22'h7, 22'h300);
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL load_enters_e: got %h want %h", o, e); end
    issue(mk_instr(3'd4, 3'd2, 5'd6), 8'h01, 22'h9, 22'h304);
    #1; n_checks++;
    if (stall_d !== 1'b1) begin n_fail++; $display("FAIL stall_on_rs2: got %b want 1", stall_d); end
    tick();
    exp_haz++;
    n_checks++;
    if (valid_e !== 1'b0 || ctrl_e !== 8'h00 || pc_e !== 22'h300 || rd_e !== 5'd2) begin
      n_fail++;
      $display("FAIL bubble_rs2: got v=%b c=%h pc=%h rd=%0d want v=0 c=00 pc=300 rd=2",
               valid_e, ctrl_e, pc_e, rd_e);
    end
    n_checks++;
    if (hazard_cnt !== CNT_W'(exp_haz)) begin
      n_fail++; $display("FAIL hazard_cnt_rs2: got %0d want %0d", hazard_cnt, exp_haz);
    end
    n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL stall_one_cycle: got %b want 0", stall_d); end
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL dep_enters_rs2: got %h want %h", o, e); end
    // rs1 dependency on a load.
    issue(mk_instr(3'd0, 3'd0, 5'd3), 8'h09, 22'h0, 22'h308);
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL load2_enters_e: got %h want %h", o, e); end
    issue(mk_instr(3'd3, 3'd1, 5'd4), 8'h01, 22'h0, 22'h30C);
    tick();
    exp_haz++;
    n_checks++;
    if (valid_e !== 1'b0 || hazard_cnt !== CNT_W'(exp_haz)) begin
      n_fail++;
      $display("FAIL bubble_rs1: got v=%b cnt=%0d want v=0 cnt=%0d", valid_e, hazard_cnt, exp_haz);
    end
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL dep_enters_rs1: got %h want %h", o, e); end
    // Producer is not a load: no stall.
    issue(mk_instr(3'd4, 3'd4, 5'd1), 8'h01, 22'h0, 22'h310);
    #1; n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL no_stall_nonload: got %b want 0", stall_d); end
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL nonload_advance: got %h want %h", o, e); end
    // Load to register 0: no stall.
    issue(mk_instr(3'd0, 3'd0, 5'd0), 8'h09, 22'h0, 22'h314);
    sb.push_back(exp_load());
    tick();
    void'(sb.pop_front());
    issue(mk_instr(3'd0, 3'd0, 5'd5), 8'h01, 22'h0, 22'h318);
    #1; n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL no_stall_rd0: got %b want 0", stall_d); end
    sb.push_back(exp_load());
    tick();
    void'(sb.pop_front());
    // Load to an out-of-file destination (5'b01010) must not match rs=2.
    issue(mk_instr(3'd0, 3'd0, 5'b01010), 8'h09, 22'h0, 22'h31C);
    sb.push_back(exp_load());
    tick();
    void'(sb.pop_front());
    issue(mk_instr(3'd2, 3'd2, 5'd1), 8'h01, 22'h0, 22'h320);
    #1; n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL no_stall_rd_hi: got %b want 0", stall_d); end
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL rd_hi_advance: got %h want %h", o, e); end
    idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    e_t e, o;
    idle();
    issue(mk_instr(3'd0, 3'd0, 5'd2), 8'h09, 22'h11, 22'h400);
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL flush_setup: got %h want %h", o, e); end
    issue(mk_instr(3'd2, 3'd0, 5'd3), 8'h01, 22'h12, 22'h404);
    stall_ext = 1'b1; flush_e = 1'b1;
    #1; n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL flush_beats_stall: got %b want 0", stall_d); end
    tick();
    exp_flush++;
    o = obs_e(); n_checks++;
    if (o !== '0) begin n_fail++; $display("FAIL flush_clears_e: got %h want 0", o); end
    n_checks++;
    if (flush_cnt !== CNT_W'(exp_flush) || hazard_cnt !== CNT_W'(exp_haz)) begin
      n_fail++;
      $display("FAIL flush_counts: got f=%0d h=%0d want f=%0d h=%0d", flush_cnt, hazard_cnt,
               exp_flush, exp_haz);
    end
    stall_ext = 1'b0; flush_e = 1'b0;
    sb.push_back(exp_load());
    tick();
    e = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL after_flush_advance: got %h want %h", o, e); end
    idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall_ext();
    e_t held, o;
    idle();
    issue(mk_instr(3'd1, 3'd2, 5'd3), 8'h25, 22'h3ABCD, 22'h500);
    sb.push_back(exp_load());
    tick();
    held = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== held) begin n_fail++; $display("FAIL stall_setup: got %h want %h", o, held); end
    issue(mk_instr(3'd5, 3'd6, 5'd7), 8'h41, 22'h1, 22'h504);
    stall_ext = 1'b1;
    we_w = 1'b1; rd_w = 5'd6; wd_w = 22'h0BEEF;
    for (int k = 0; k < 3; k++) begin
      #1; n_checks++;
      if (stall_d !== 1'b1) begin n_fail++; $display("FAIL stall_ext_d_c%0d: got %b want 1", k, stall_d); end
      tick();
      we_w = 1'b0;
      o = obs_e(); n_checks++;
      if (o !== held) begin n_fail++; $display("FAIL stall_ext_hold_c%0d: got %h want %h", k, o, held); end
      n_checks++;
      if (hazard_cnt !== CNT_W'(exp_haz) || flush_cnt !== CNT_W'(exp_flush)) begin
        n_fail++;
        $display("FAIL stall_ext_counts_c%0d: got h=%0d f=%0d want h=%0d f=%0d", k, hazard_cnt,
                 flush_cnt, exp_haz, exp_flush);
      end
    end
    stall_ext = 1'b0;
    sb.push_back(exp_load());
    tick();
    held = sb.pop_front(); o = obs_e(); n_checks++;
    if (o !== held) begin n_fail++; $display("FAIL resume_after_stall: got %h want %h", o, held); end
    idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_saturation();
    e_t e, o;
    int sat_exp;
    tick();
    rst = 1'b0; clear_model();
    #1 rst = 1'b1;
    idle();
    for (int k = 1; k <= 5; k++) begin
      issue(mk_instr(3'd0, 3'd0, 5'd1), 8'h09, 22'h0, DATA_W'(22'h600 + k * 16));
      sb.push_back(exp_load());
      tick();
      void'(sb.pop_front());
      issue(mk_instr(3'd1, 3'd0, 5'd2), 8'h01, 22'h0, DATA_W'(22'h604 + k * 16));
      tick();
      exp_haz++;
      sat_exp = (exp_haz > 3) ? 3 : exp_haz;
      n_checks++;
      if (hazard_cnt !== CNT_W'(exp_haz) || s_hazard_cnt !== SAT_W'(sat_exp)) begin
        n_fail++;
        $display("FAIL sat_hazard_%0d: got %0d/%0d want %0d/%0d", k, hazard_cnt, s_hazard_cnt,
                 exp_haz, sat_exp);
      end
      sb.push_back(exp_load());
      tick();
      e = sb.pop_front(); o = obs_e(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL sat_dep_%0d: got %h want %h", k, o, e); end
    end
    idle();
  endtask

  initial begin
    idle();
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_bypass();
    test_load_use();
    test_flush();
    test_stall_ext();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
